// File: rtl/regfile_stream_reader.sv
// Walks a range of register-file indices through a single read port and streams
// each captured value out as an (index, data) beat over a valid/ready handshake.
module regfile_stream_reader #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned DEPTH    = 32,
  parameter int unsigned IDX_W    = 5,
  parameter int unsigned READ_LAT = 0
) (
  input  logic             clock,
  input  logic             clear_n,
  input  logic             start,
  input  logic [IDX_W-1:0] first_index,
  input  logic [IDX_W-1:0] last_index,
  input  logic             abort,
  output logic [IDX_W-1:0] rf_read_index,
  input  logic [WIDTH-1:0] rf_read_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [IDX_W-1:0] out_index,
  output logic             busy,
  output logic             done
);

  // remaining must hold DEPTH itself, hence one extra bit
  localparam int unsigned CNT_W  = IDX_W + 1;
  localparam int unsigned WAIT_W = 2;

  typedef enum logic [1:0] {IDLE, READ, WAIT, OUT} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   cur_q, cur_d;
  logic [CNT_W-1:0]   rem_q, rem_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic [IDX_W-1:0]   rd_idx_d;
  logic               valid_d;
  logic [WIDTH-1:0]   data_d;
  logic [IDX_W-1:0]   oidx_d;
  logic               busy_d;
  logic               done_d;

  // State and registered outputs
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state_q       <= IDLE;
      cur_q         <= '0;
      rem_q         <= '0;
      wait_q        <= '0;
      rf_read_index <= '0;
      out_valid     <= 1'b0;
      out_data      <= '0;
      out_index     <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      state_q       <= state_d;
      cur_q         <= cur_d;
      rem_q         <= rem_d;
      wait_q        <= wait_d;
      rf_read_index <= rd_idx_d;
      out_valid     <= valid_d;
      out_data      <= data_d;
      out_index     <= oidx_d;
      busy          <= busy_d;
      done          <= done_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d  = state_q;
    cur_d    = cur_q;
    rem_d    = rem_q;
    wait_d   = wait_q;
    rd_idx_d = rf_read_index;
    valid_d  = out_valid;
    data_d   = out_data;
    oidx_d   = out_index;
    done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          cur_d    = first_index;
          rem_d    = CNT_W'(IDX_W'(last_index - first_index)) + CNT_W'(1);
          rd_idx_d = first_index;
          state_d  = READ;
        end
      end
      READ: begin
        if (READ_LAT == 0) begin
          data_d  = rf_read_data;
          oidx_d  = cur_q;
          valid_d = 1'b1;
          state_d = OUT;
        end else begin
          wait_d  = WAIT_W'(READ_LAT - 1);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (wait_q == '0) begin
          data_d  = rf_read_data;
          oidx_d  = cur_q;
          valid_d = 1'b1;
          state_d = OUT;
        end else begin
          wait_d = wait_q - WAIT_W'(1);
        end
      end
      OUT: begin
        if (out_ready) begin
          valid_d = 1'b0;
          cur_d   = cur_q + IDX_W'(1);
          rem_d   = rem_q - CNT_W'(1);
          if (rem_q == CNT_W'(1)) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            rd_idx_d = cur_q + IDX_W'(1);
            state_d  = READ;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Cancel wins over any handshake in the same cycle; the beat is not consumed
    if (abort && (state_q != IDLE)) begin
      state_d  = IDLE;
      cur_d    = cur_q;
      rem_d    = rem_q;
      rd_idx_d = rf_read_index;
      valid_d  = 1'b0;
      done_d   = 1'b0;
    end

    busy_d = (state_d != IDLE);
  end

endmodule

// File: tb/tb_regfile_stream_reader.sv
// Self-checking bench: two readers (read latency 0 and 2) against a register-file
// model, with expected beat sequences derived from the index range arithmetic.
module tb_regfile_stream_reader;

  localparam int unsigned W  = 32;
  localparam int unsigned D  = 32;
  localparam int unsigned IW = 5;

  logic          clock;
  logic          clear_n;
  logic [IW-1:0] first_index, last_index;

  logic          start0, abort0, ready0, valid0, busy0, done0;
  logic [IW-1:0] ridx0, oidx0;
  logic [W-1:0]  rdata0, odata0;

  logic          start2, abort2, ready2, valid2, busy2, done2;
  logic [IW-1:0] ridx2, oidx2;
  logic [W-1:0]  rdata2, odata2;

  logic [W-1:0]  rf [D];
  logic [W-1:0]  p1, p2;

  int pass_cnt, check_cnt;

  int           got_idx[$];
  logic [W-1:0] got_data[$];
  int           got_cyc[$];
  int           exp_idx[$];
  int           first_valid, done_cnt, done_cyc, hold_err, overlap_err;
  bit           timed_out, aborted;
  logic         post_v, post_b;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Register file: combinational read for dut0, two-cycle pipelined read for dut2
  assign rdata0 = rf[ridx0];
  always @(posedge clock) begin
    p1 <= rf[ridx2];
    p2 <= p1;
  end
  assign rdata2 = p2;

  regfile_stream_reader #(.WIDTH(W), .DEPTH(D), .IDX_W(IW), .READ_LAT(0)) dut0 (
    .clock(clock), .clear_n(clear_n), .start(start0),
    .first_index(first_index), .last_index(last_index), .abort(abort0),
    .rf_read_index(ridx0), .rf_read_data(rdata0),
    .out_valid(valid0), .out_ready(ready0), .out_data(odata0), .out_index(oidx0),
    .busy(busy0), .done(done0));

  regfile_stream_reader #(.WIDTH(W), .DEPTH(D), .IDX_W(IW), .READ_LAT(2)) dut2 (
    .clock(clock), .clear_n(clear_n), .start(start2),
    .first_index(first_index), .last_index(last_index), .abort(abort2),
    .rf_read_index(ridx2), .rf_read_data(rdata2),
    .out_valid(valid2), .out_ready(ready2), .out_data(odata2), .out_index(oidx2),
    .busy(busy2), .done(done2));

  function automatic void build_expected(input int f, input int l);
    int n;
    int dd;
    dd = int'(D);
    exp_idx.delete();
    n = ((l - f + dd) % dd) + 1;
    for (int k = 0; k < n; k++) exp_idx.push_back((f + k) % dd);
  endfunction

  task automatic drive(input int sel, input logic st, input logic ab, input logic rd);
    if (sel == 0) begin start0 = st; abort0 = ab; ready0 = rd; end
    else          begin start2 = st; abort2 = ab; ready2 = rd; end
  endtask

  // Runs one dump on the selected reader and records what it produced
  task automatic do_dump(input int sel, input int f, input int l, input int rpct,
                         input int stall_beat, input int stall_len, input int abort_beat);
    int cyc, stall, nbeat;
    logic v, b, dn, r, pend;
    logic [W-1:0] d, pd;
    logic [IW-1:0] i, pi;
    got_idx.delete(); got_data.delete(); got_cyc.delete();
    first_valid = -1; done_cnt = 0; done_cyc = -1; hold_err = 0; overlap_err = 0;
    timed_out = 0; aborted = 0; post_v = 1'b0; post_b = 1'b0;
    cyc = 0; stall = 0; nbeat = 0; pend = 1'b0; pd = '0; pi = '0;
    @(posedge clock); #1;
    first_index = IW'(f);
    last_index  = IW'(l);
    drive(sel, 1'b1, 1'b0, 1'b0);
    forever begin
      @(posedge clock); cyc++; #1;
      first_index = IW'($urandom);
      last_index  = IW'($urandom);
      v  = (sel == 0) ? valid0 : valid2;
      b  = (sel == 0) ? busy0  : busy2;
      dn = (sel == 0) ? done0  : done2;
      d  = (sel == 0) ? odata0 : odata2;
      i  = (sel == 0) ? oidx0  : oidx2;
      if (dn) begin done_cnt++; done_cyc = cyc; end
      if (dn && v) overlap_err++;
      if (aborted) begin
        post_v = v; post_b = b;
        drive(sel, 1'b0, 1'b0, 1'b0);
        break;
      end
      r = 1'b0;
      if (v) begin
        if (first_valid < 0) first_valid = cyc;
        if (pend && (d !== pd || i !== pi)) hold_err++;
        if (nbeat == stall_beat && stall < stall_len) begin
          r = 1'b0; stall++;
        end else begin
          r = ($urandom_range(99) < rpct) ? 1'b1 : 1'b0;
        end
        if (nbeat == abort_beat) r = 1'b1;
        if (nbeat == abort_beat) begin
          aborted = 1;
        end else if (r) begin
          got_idx.push_back(int'(i)); got_data.push_back(d); got_cyc.push_back(cyc);
          nbeat++; pend = 1'b0;
        end else begin
          pend = 1'b1; pd = d; pi = i;
        end
      end else begin
        r = $urandom_range(1) == 1;
      end
      drive(sel, 1'b0, aborted ? 1'b1 : 1'b0, r);
      if (!b && !dn && cyc > 1 && !aborted) break;
      if (cyc > 1000) begin timed_out = 1; break; end
    end
    drive(sel, 1'b0, 1'b0, 1'b0);
    if (aborted) begin
      repeat (3) begin
        @(posedge clock); #1;
        if ((sel == 0) ? done0 : done2) done_cnt++;
      end
    end
  endtask

  task automatic test_reset();
    #2;
    check_cnt++; if ({valid0, busy0, done0} !== 3'b000) $display("FAIL reset_ctl0: got %b want 000", {valid0, busy0, done0}); else pass_cnt++;
    check_cnt++; if ({ridx0, oidx0} !== '0) $display("FAIL reset_idx0: got %h want 0", {ridx0, oidx0}); else pass_cnt++;
    check_cnt++; if (odata0 !== '0) $display("FAIL reset_data0: got %h want 0", odata0); else pass_cnt++;
    check_cnt++; if ({valid2, busy2, done2, ridx2, oidx2} !== '0) $display("FAIL reset_2: got %h want 0", {valid2, busy2, done2, ridx2, oidx2}); else pass_cnt++;
  endtask

  task automatic test_single_beat();
    rf[3] = 32'hFF;
    do_dump(0, 3, 3, 100, -1, 0, -1);
    check_cnt++; if (got_idx.size() !== 1) $display("FAIL single_count: got %0d want 1", got_idx.size()); else pass_cnt++;
    if (got_idx.size() == 1) begin
      check_cnt++; if (got_idx[0] !== 3 || got_data[0] !== 32'hFF) $display("FAIL single_beat: got idx %0d data %h want 3 ff", got_idx[0], got_data[0]); else pass_cnt++;
      check_cnt++; if (done_cyc !== got_cyc[0] + 1) $display("FAIL single_done_time: got %0d want %0d", done_cyc, got_cyc[0] + 1); else pass_cnt++;
    end
    check_cnt++; if (first_valid !== 2) $display("FAIL single_latency: got %0d want 2", first_valid); else pass_cnt++;
    check_cnt++; if (done_cnt !== 1 || timed_out) $display("FAIL single_done: got %0d pulses timeout %0d want 1 0", done_cnt, timed_out); else pass_cnt++;
    check_cnt++; if (busy0 !== 1'b0) $display("FAIL single_busy_after: got %b want 0", busy0); else pass_cnt++;
  endtask

  task automatic test_wrap();
    rf[30] = 32'd30; rf[31] = 32'd31; rf[0] = 32'd100; rf[1] = 32'd101;
    build_expected(30, 1);
    do_dump(0, 30, 1, 100, -1, 0, -1);
    check_cnt++; if (got_idx.size() !== exp_idx.size()) $display("FAIL wrap_count: got %0d want %0d", got_idx.size(), exp_idx.size()); else pass_cnt++;
    for (int k = 0; k < exp_idx.size() && k < got_idx.size(); k++) begin
      check_cnt++; if (got_idx[k] !== exp_idx[k] || got_data[k] !== rf[exp_idx[k]]) $display("FAIL wrap_beat%0d: got %0d/%h want %0d/%h", k, got_idx[k], got_data[k], exp_idx[k], rf[exp_idx[k]]); else pass_cnt++;
      if (k > 0) begin
        check_cnt++; if (got_cyc[k] - got_cyc[k-1] !== 2) $display("FAIL wrap_spacing%0d: got %0d want 2", k, got_cyc[k] - got_cyc[k-1]); else pass_cnt++;
      end
    end
    check_cnt++; if (done_cnt !== 1 || overlap_err !== 0) $display("FAIL wrap_done: got %0d pulses %0d overlaps want 1 0", done_cnt, overlap_err); else pass_cnt++;
  endtask

  task automatic test_backpressure();
    for (int k = 0; k < 3; k++) rf[k] = $urandom;
    build_expected(0, 2);
    do_dump(0, 0, 2, 100, 1, 5, -1);
    check_cnt++; if (hold_err !== 0) $display("FAIL bp_hold: got %0d changes want 0", hold_err); else pass_cnt++;
    check_cnt++; if (got_idx.size() !== 3) $display("FAIL bp_count: got %0d want 3", got_idx.size()); else pass_cnt++;
    for (int k = 0; k < 3 && k < got_idx.size(); k++) begin
      check_cnt++; if (got_idx[k] !== exp_idx[k] || got_data[k] !== rf[exp_idx[k]]) $display("FAIL bp_beat%0d: got %0d/%h want %0d/%h", k, got_idx[k], got_data[k], exp_idx[k], rf[exp_idx[k]]); else pass_cnt++;
    end
    if (got_cyc.size() >= 2) begin
      check_cnt++; if (got_cyc[1] - got_cyc[0] !== 7) $display("FAIL bp_stall_len: got %0d want 7", got_cyc[1] - got_cyc[0]); else pass_cnt++;
    end
    check_cnt++; if (done_cnt !== 1) $display("FAIL bp_done: got %0d want 1", done_cnt); else pass_cnt++;
  endtask

  task automatic test_lat2();
    rf[5] = $urandom; rf[6] = $urandom;
    do_dump(2, 5, 6, 100, -1, 0, -1);
    check_cnt++; if (first_valid !== 4) $display("FAIL lat2_latency: got %0d want 4", first_valid); else pass_cnt++;
    check_cnt++; if (got_idx.size() !== 2) $display("FAIL lat2_count: got %0d want 2", got_idx.size()); else pass_cnt++;
    if (got_idx.size() == 2) begin
      check_cnt++; if (got_data[0] !== rf[5] || got_data[1] !== rf[6] || got_idx[0] !== 5 || got_idx[1] !== 6) $display("FAIL lat2_data: got %h %h want %h %h", got_data[0], got_data[1], rf[5], rf[6]); else pass_cnt++;
      check_cnt++; if (got_cyc[1] - got_cyc[0] !== 4) $display("FAIL lat2_spacing: got %0d want 4", got_cyc[1] - got_cyc[0]); else pass_cnt++;
    end
    check_cnt++; if (done_cnt !== 1) $display("FAIL lat2_done: got %0d want 1", done_cnt); else pass_cnt++;
  endtask

  task automatic test_abort();
    for (int k = 0; k < 4; k++) rf[k] = $urandom;
    do_dump(0, 0, 3, 100, -1, 0, 1);
    check_cnt++; if (got_idx.size() !== 1) $display("FAIL abort_beats: got %0d want 1", got_idx.size()); else pass_cnt++;
    check_cnt++; if (post_v !== 1'b0 || post_b !== 1'b0) $display("FAIL abort_state: got valid %b busy %b want 0 0", post_v, post_b); else pass_cnt++;
    check_cnt++; if (done_cnt !== 0) $display("FAIL abort_done: got %0d want 0", done_cnt); else pass_cnt++;
    do_dump(0, 0, 0, 100, -1, 0, -1);
    check_cnt++; if (got_idx.size() !== 1 || done_cnt !== 1) $display("FAIL abort_restart: got %0d beats %0d done want 1 1", got_idx.size(), done_cnt); else pass_cnt++;
    if (got_idx.size() == 1) begin
      check_cnt++; if (got_idx[0] !== 0 || got_data[0] !== rf[0]) $display("FAIL abort_restart_beat: got %0d/%h want 0/%h", got_idx[0], got_data[0], rf[0]); else pass_cnt++;
    end
  endtask

  task automatic test_idle_abort();
    @(posedge clock); #1;
    first_index = 5'd4; last_index = 5'd9;
    start0 = 1'b1; abort0 = 1'b1;
    @(posedge clock); #1;
    start0 = 1'b0; abort0 = 1'b0;
    check_cnt++; if (busy0 !== 1'b0) $display("FAIL idle_abort_busy: got %b want 0", busy0); else pass_cnt++;
    @(posedge clock); #1;
    check_cnt++; if (valid0 !== 1'b0 || busy0 !== 1'b0) $display("FAIL idle_abort_state: got %b%b want 00", valid0, busy0); else pass_cnt++;
  endtask

  task automatic test_async_reset();
    int dn;
    dn = 0;
    @(posedge clock); #1;
    first_index = 5'd8; last_index = 5'd15;
    start0 = 1'b1; ready0 = 1'b1;
    @(posedge clock); #1;
    start0 = 1'b0;
    repeat (2) @(posedge clock);
    #2;
    check_cnt++; if (busy0 !== 1'b1) $display("FAIL arst_pre_busy: got %b want 1", busy0); else pass_cnt++;
    clear_n = 1'b0;
    #1;
    check_cnt++; if (valid0 !== 1'b0 || busy0 !== 1'b0 || done0 !== 1'b0) $display("FAIL arst_ctl: got %b%b%b want 000", valid0, busy0, done0); else pass_cnt++;
    check_cnt++; if (ridx0 !== '0 || oidx0 !== '0 || odata0 !== '0) $display("FAIL arst_data: got %h %h %h want 0", ridx0, oidx0, odata0); else pass_cnt++;
    start0 = 1'b1; first_index = 5'd1; last_index = 5'd2;
    @(posedge clock); #1;
    check_cnt++; if (busy0 !== 1'b0) $display("FAIL arst_start_ignored: got %b want 0", busy0); else pass_cnt++;
    start0 = 1'b0; ready0 = 1'b0;
    clear_n = 1'b1;
    repeat (4) begin
      @(posedge clock); #1;
      if (done0 || busy0 || valid0) dn++;
    end
    check_cnt++; if (dn !== 0) $display("FAIL arst_after: got %0d active cycles want 0", dn); else pass_cnt++;
  endtask

  task automatic test_random();
    int f, l, sel;
    for (int it = 0; it < 6; it++) begin
      for (int k = 0; k < int'(D); k++) rf[k] = $urandom;
      sel = (it % 2 == 0) ? 0 : 2;
      f = $urandom_range(D - 1);
      l = $urandom_range(D - 1);
      if (it == 5) l = (f + int'(D) - 1) % int'(D);
      build_expected(f, l);
      do_dump(sel, f, l, $urandom_range(100, 40), -1, 0, -1);
      check_cnt++; if (got_idx.size() !== exp_idx.size() || timed_out) $display("FAIL rand%0d_count: got %0d want %0d (first %0d last %0d)", it, got_idx.size(), exp_idx.size(), f, l); else pass_cnt++;
      for (int k = 0; k < exp_idx.size() && k < got_idx.size(); k++) begin
        check_cnt++; if (got_idx[k] !== exp_idx[k] || got_data[k] !== rf[exp_idx[k]]) $display("FAIL rand%0d_beat%0d: got %0d/%h want %0d/%h", it, k, got_idx[k], got_data[k], exp_idx[k], rf[exp_idx[k]]); else pass_cnt++;
      end
      check_cnt++; if (done_cnt !== 1 || hold_err !== 0 || overlap_err !== 0) $display("FAIL rand%0d_proto: got done %0d hold %0d overlap %0d want 1 0 0", it, done_cnt, hold_err, overlap_err); else pass_cnt++;
    end
  endtask

  initial begin
    pass_cnt = 0; check_cnt = 0;
    clear_n = 1'b0;
    first_index = '0; last_index = '0;
    start0 = 1'b0; abort0 = 1'b0; ready0 = 1'b0;
    start2 = 1'b0; abort2 = 1'b0; ready2 = 1'b0;
    for (int k = 0; k < int'(D); k++) rf[k] = '0;
    #10;
    test_reset();
    #10 clear_n = 1'b1;
    test_single_beat();
    test_wrap();
    test_backpressure();
    test_lat2();
    test_abort();
    test_idle_abort();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule

// File: doc/regfile_stream_reader.md
Name: regfile_stream_reader

Overview:
- Read-side companion to the team's dual-write 32x32 register file.
- On a start command, walks a range of register indices through the file's single read port.
- Captures each value and streams it out as (index, data) beats over a valid/ready handshake.
- Used for register-file dump/debug and for bulk transfer to downstream consumers.

Parameters:
- WIDTH, 32, data width of one register.
- DEPTH, 32, number of registers; must be a power of two.
- IDX_W, 5, index width, log2(DEPTH).
- READ_LAT, 0, register-file read latency in cycles; legal values 0, 1, 2.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- clear_n  in  1  asynchronous, active-low reset.
- start  in  1  begin a dump; sampled only in IDLE.
- first_index  in  IDX_W  first register to read; captured with start.
- last_index  in  IDX_W  last register to read, inclusive; captured with start.
- abort  in  1  synchronous cancel of a dump in progress.
- rf_read_index  out  IDX_W  index driven to the register-file read port.
- rf_read_data  in  WIDTH  register-file read value.
- out_valid  out  1  beat available on out_data/out_index.
- out_ready  in  1  consumer accepts the beat.
- out_data  out  WIDTH  captured register value.
- out_index  out  IDX_W  index of the register in out_data.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse after the last beat is accepted.

Behaviour:
- Reset (clear_n=0, asynchronous):
  - State goes to IDLE.
  - All outputs go to 0: rf_read_index, out_valid, out_data, out_index, busy, done.
  - Internal counters are cleared.
- States: IDLE, READ, WAIT, OUT.
- IDLE:
  - start=1 latches cur=first_index and remaining=((last_index-first_index) mod DEPTH)+1, then moves to READ.
  - last<first wraps through DEPTH-1 to 0. first==last gives 1 beat.
  - No full-file mode; a maximum-length run is DEPTH beats (last=first-1).
- READ:
  - rf_read_index=cur; rf_read_index holds cur until the next READ.
  - READ_LAT=0: rf_read_data is captured this cycle, then OUT.
  - READ_LAT>0: go to WAIT for READ_LAT cycles, capture on the last WAIT cycle, then OUT.
- OUT:
  - out_valid=1; out_data and out_index=cur are stable while out_ready=0.
  - On out_valid&out_ready: cur=(cur+1) mod DEPTH and remaining decrements.
  - If remaining was 1: done=1 next cycle, busy=0, state IDLE. Otherwise state READ.
- Throughput: one beat per 2+READ_LAT cycles with out_ready held high.
- Latency: start at edge T gives first out_valid at edge T+2+READ_LAT.
- abort=1 in any non-IDLE state:
  - Next state IDLE, out_valid=0, no done pulse.
  - abort wins over a simultaneous handshake; that beat counts as not transferred.
- start while busy is ignored; first_index and last_index are don't-care after capture.
- abort in IDLE has no effect. start and abort together in IDLE: abort wins, stay IDLE.
- done and out_valid are never high in the same cycle.
- Mid-dump register-file writes: the value captured is whatever rf_read_data shows at capture; no coherence guarantee.
- Asynchronous reset mid-dump: immediate return to IDLE with all outputs 0. No done pulse afterwards.

Test Plan:
- Single beat, reg 3 preloaded 0xFF, READ_LAT=0, start with first=3/last=3, out_ready=1 -> out_valid at T+2 with out_data=0xFF, out_index=3; done pulses one cycle later; busy low after.
- Wrap range, regs 30,31,0,1 preloaded 30,31,100,101, first=30/last=1 -> 4 beats with indices 30,31,0,1 and matching data, one per 2 cycles, then one done pulse.
- Backpressure, first=0/last=2, out_ready low for 5 cycles on beat 1 -> out_data/out_index held constant throughout, no index skipped, exactly 3 beats total.
- READ_LAT=2, first=5/last=6 -> first out_valid at T+4; beats spaced 4 cycles apart; data matches regs 5 and 6.
- abort during the second beat's OUT with out_ready=1 in the same cycle -> out_valid low next cycle, state IDLE, no done; a new start with first=0/last=0 works normally.
- clear_n pulsed low mid-dump between clock edges -> out_valid, busy, rf_read_index go to 0 immediately; no done; start ignored until clear_n returns high.
